// File: rtl/id_ex_pkg.sv
// Shared widths and payload layout for the ID/EX pipeline stage.
// The struct documents the default field order used when flattening the payload.
package id_ex_pkg;

    localparam int unsigned DEF_WB_W   = 2;
    localparam int unsigned DEF_MEM_W  = 3;
    localparam int unsigned DEF_EX_W   = 4;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_W  = 5;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef struct packed {
        logic [DEF_WB_W-1:0]   wb;
        logic [DEF_MEM_W-1:0]  mem;
        logic [DEF_EX_W-1:0]   ex;
        logic [DEF_DATA_W-1:0] npc;
        logic [DEF_DATA_W-1:0] rd1;
        logic [DEF_DATA_W-1:0] rd2;
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_REG_W-1:0]  rt;
        logic [DEF_REG_W-1:0]  rd;
    } id_ex_payload_t;

    localparam int unsigned ID_EX_PAYLOAD_W = $bits(id_ex_payload_t);

    function automatic int unsigned payload_width(
        input int unsigned wb_w,
        input int unsigned mem_w,
        input int unsigned ex_w,
        input int unsigned data_w,
        input int unsigned reg_w
    );
        return wb_w + mem_w + ex_w + 4 * data_w + 2 * reg_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer. in_ready_o depends only on flops, so no
// combinational path runs from out_ready_i back to the producer.
module pipe_skid_buf
    import id_ex_pkg::*;
#(
    parameter int unsigned WIDTH = ID_EX_PAYLOAD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             accept;
    logic             drain;

    assign in_ready_o  = !s_valid_q;
    assign out_valid_o = m_valid_q;
    assign out_data_o  = m_data_q;
    assign accept      = in_valid_i & !s_valid_q;
    assign drain       = m_valid_q & out_ready_i;

    // S only ever holds the entry behind M, so refilling M from S keeps FIFO order.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q && drain) begin
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
        end else if (!s_valid_q && (!m_valid_q || drain)) begin
            m_valid_d = accept;
            if (accept) begin
                m_data_d = in_data_i;
            end
        end else if (!s_valid_q && m_valid_q && !drain && accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with skid buffering, bubble insertion, output
// control gating and a saturating back-pressure cycle counter.
module id_ex_skid_stage
    import id_ex_pkg::*;
#(
    parameter int unsigned WB_W   = DEF_WB_W,
    parameter int unsigned MEM_W  = DEF_MEM_W,
    parameter int unsigned EX_W   = DEF_EX_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bubble,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [MEM_W-1:0]  in_mem,
    input  logic [EX_W-1:0]   in_ex,
    input  logic [DATA_W-1:0] in_npc,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb,
    output logic [MEM_W-1:0]  out_mem,
    output logic [EX_W-1:0]   out_ex,
    output logic [DATA_W-1:0] out_npc,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned      PAY_W   = payload_width(WB_W, MEM_W, EX_W, DATA_W, REG_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WB_W-1:0]  wb_in_m;
    logic [MEM_W-1:0] mem_in_m;
    logic [EX_W-1:0]  ex_in_m;
    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;
    logic [WB_W-1:0]  wb_raw;
    logic [MEM_W-1:0] mem_raw;
    logic [EX_W-1:0]  ex_raw;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A bubble is still a real, valid entry; only its control bundles are cleared.
    assign wb_in_m  = in_bubble ? '0 : in_wb;
    assign mem_in_m = in_bubble ? '0 : in_mem;
    assign ex_in_m  = in_bubble ? '0 : in_ex;
    assign pay_in   = {wb_in_m, mem_in_m, ex_in_m, in_npc, in_rd1, in_rd2, in_imm, in_rt, in_rd};

    pipe_skid_buf #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (pay_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (pay_out)
    );

    assign {wb_raw, mem_raw, ex_raw, out_npc, out_rd1, out_rd2, out_imm, out_rt, out_rd} = pay_out;

    // Stale control must never reach EX once the held entry is gone.
    assign out_wb  = out_valid ? wb_raw  : '0;
    assign out_mem = out_valid ? mem_raw : '0;
    assign out_ex  = out_valid ? ex_raw  : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Self-checking bench for id_ex_skid_stage: directed scenarios plus a random
// run checked against a depth-2 FIFO reference model.
module tb_id_ex_skid_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_bubble;
    logic [1:0]  in_wb;
    logic [2:0]  in_mem;
    logic [3:0]  in_ex;
    logic [31:0] in_npc, in_rd1, in_rd2, in_imm;
    logic [4:0]  in_rt, in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_wb;
    logic [2:0]  out_mem;
    logic [3:0]  out_ex;
    logic [31:0] out_npc, out_rd1, out_rd2, out_imm;
    logic [4:0]  out_rt, out_rd;
    logic        stat_clr;
    logic [3:0]  stall_cycles;

    int pass_cnt  = 0;
    int total_cnt = 0;

    id_ex_skid_stage #(
        .WB_W(2), .MEM_W(3), .EX_W(4), .DATA_W(32), .REG_W(5), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble),
        .in_wb(in_wb), .in_mem(in_mem), .in_ex(in_ex),
        .in_npc(in_npc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb(out_wb), .out_mem(out_mem), .out_ex(out_ex),
        .out_npc(out_npc), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
        .out_rt(out_rt), .out_rd(out_rd),
        .stat_clr(stat_clr), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        in_bubble = 1'b0;
        flush     = 1'b0;
        stat_clr  = 1'b0;
        in_wb = '0; in_mem = '0; in_ex = '0;
        in_npc = '0; in_rd1 = '0; in_rd2 = '0; in_imm = '0;
        in_rt = '0; in_rd = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if ({out_wb, out_mem, out_ex} !== 9'h0) $display("FAIL reset_ctrl got %h exp 0", {out_wb, out_mem, out_ex}); else pass_cnt++;
        total_cnt++; if (out_npc !== 32'h0 || out_rd1 !== 32'h0) $display("FAIL reset_data got %h/%h exp 0", out_npc, out_rd1); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4'h0) $display("FAIL reset_stall got %0d exp 0", stall_cycles); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_stream();
        drive_idle();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_npc   = 32'(i * 4);
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_ready%0d got %b exp 1", i, in_ready); else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_npc !== 32'(i * 4))
                $display("FAIL stream_out%0d got v=%b npc=%h exp v=1 npc=%h", i, out_valid, out_npc, 32'(i * 4));
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4'h0) $display("FAIL stream_stall got %0d exp 0", stall_cycles); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        drive_idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_npc    = 32'h100;
        tick();
        total_cnt++; if (in_ready !== 1'b1 || out_npc !== 32'h100) $display("FAIL bp_first got rdy=%b npc=%h exp rdy=1 npc=100", in_ready, out_npc); else pass_cnt++;
        in_npc = 32'h104;
        tick();
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full got rdy=%b exp 0", in_ready); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4'd1) $display("FAIL bp_stall1 got %0d exp 1", stall_cycles); else pass_cnt++;
        in_npc = 32'h108;
        tick();
        total_cnt++; if (out_npc !== 32'h100 || in_ready !== 1'b0) $display("FAIL bp_hold got npc=%h rdy=%b exp npc=100 rdy=0", out_npc, in_ready); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4'd2) $display("FAIL bp_stall2 got %0d exp 2", stall_cycles); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b1 || out_npc !== 32'h104 || in_ready !== 1'b1) $display("FAIL bp_second got v=%b npc=%h rdy=%b exp v=1 npc=104 rdy=1", out_valid, out_npc, in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b1 || out_npc !== 32'h108) $display("FAIL bp_third got v=%b npc=%h exp v=1 npc=108", out_valid, out_npc); else pass_cnt++;
        in_valid = 1'b0;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4'd2) $display("FAIL bp_stall_final got %0d exp 2", stall_cycles); else pass_cnt++;
    endtask

    task automatic test_bubble();
        drive_idle();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_wb = 2'b11; in_mem = 3'b101; in_ex = 4'hF; in_rd1 = 32'hDEADBEEF;
        tick();
        total_cnt++; if ({out_wb, out_mem, out_ex} !== {2'b11, 3'b101, 4'hF}) $display("FAIL normal_ctrl got %h exp %h", {out_wb, out_mem, out_ex}, {2'b11, 3'b101, 4'hF}); else pass_cnt++;
        in_bubble = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL bubble_valid got %b exp 1", out_valid); else pass_cnt++;
        total_cnt++; if ({out_wb, out_mem, out_ex} !== 9'h0) $display("FAIL bubble_ctrl got %h exp 0", {out_wb, out_mem, out_ex}); else pass_cnt++;
        total_cnt++; if (out_rd1 !== 32'hDEADBEEF) $display("FAIL bubble_rd1 got %h exp deadbeef", out_rd1); else pass_cnt++;
        in_bubble = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        total_cnt++; if (out_valid !== 1'b0 || {out_wb, out_mem, out_ex} !== 9'h0) $display("FAIL gate_ctrl got v=%b ctrl=%h exp v=0 ctrl=0", out_valid, {out_wb, out_mem, out_ex}); else pass_cnt++;
    endtask

    task automatic test_flush();
        drive_idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_wb     = 2'b01;
        in_npc    = 32'h200;
        tick();
        in_npc = 32'h204;
        tick();
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_prefull got rdy=%b exp 0", in_ready); else pass_cnt++;
        in_npc = 32'h208;
        flush  = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b0 || {out_wb, out_mem, out_ex} !== 9'h0) $display("FAIL flush_out got v=%b ctrl=%h exp v=0 ctrl=0", out_valid, {out_wb, out_mem, out_ex}); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %b exp 1", in_ready); else pass_cnt++;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_npc    = 32'h20C;
        in_wb     = 2'b10;
        tick();
        total_cnt++; if (out_valid !== 1'b1 || out_npc !== 32'h20C || out_wb !== 2'b10) $display("FAIL flush_next got v=%b npc=%h wb=%b exp v=1 npc=20c wb=10", out_valid, out_npc, out_wb); else pass_cnt++;
        in_valid = 1'b0;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_empty got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_counter();
        drive_idle();
        out_ready = 1'b0;
        stat_clr  = 1'b1;
        in_valid  = 1'b1;
        in_npc    = 32'h300;
        tick();
        total_cnt++; if (stall_cycles !== 4'd0) $display("FAIL cnt_clr0 got %0d exp 0", stall_cycles); else pass_cnt++;
        stat_clr = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        total_cnt++; if (stall_cycles !== 4'd3) $display("FAIL cnt_3 got %0d exp 3", stall_cycles); else pass_cnt++;
        repeat (17) tick();
        total_cnt++; if (stall_cycles !== 4'd15) $display("FAIL cnt_sat got %0d exp 15", stall_cycles); else pass_cnt++;
        stat_clr = 1'b1;
        tick();
        total_cnt++; if (stall_cycles !== 4'd0) $display("FAIL cnt_clr got %0d exp 0", stall_cycles); else pass_cnt++;
        stat_clr = 1'b0;
        tick();
        total_cnt++; if (stall_cycles !== 4'd1) $display("FAIL cnt_restart1 got %0d exp 1", stall_cycles); else pass_cnt++;
        tick();
        total_cnt++; if (stall_cycles !== 4'd2) $display("FAIL cnt_restart2 got %0d exp 2", stall_cycles); else pass_cnt++;
        flush = 1'b1;
        tick();
        total_cnt++; if (stall_cycles !== 4'd3 || out_valid !== 1'b0) $display("FAIL cnt_flush got cnt=%0d v=%b exp cnt=3 v=0", stall_cycles, out_valid); else pass_cnt++;
        flush = 1'b0;
    endtask

    task automatic test_random();
        entry_t q[$];
        entry_t e, got;
        logic [3:0] mcnt;
        logic acc, drn;
        int errs;
        drive_idle();
        flush    = 1'b1;
        stat_clr = 1'b1;
        tick();
        flush    = 1'b0;
        stat_clr = 1'b0;
        mcnt = 4'd0;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            e.wb  = 2'($urandom); e.mem = 3'($urandom); e.ex = 4'($urandom);
            e.npc = $urandom; e.rd1 = $urandom; e.rd2 = $urandom; e.imm = $urandom;
            e.rt  = 5'($urandom); e.rd = 5'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bubble = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            stat_clr  = ($urandom_range(0, 63) == 0);
            {in_wb, in_mem, in_ex, in_npc, in_rd1, in_rd2, in_imm, in_rt, in_rd} = e;
            #1;
            total_cnt++;
            if (in_ready !== (q.size() < 2)) begin
                $display("FAIL rnd_ready cyc %0d got %b exp %b", i, in_ready, q.size() < 2);
                errs++;
            end else pass_cnt++;
            if (stat_clr) mcnt = 4'd0;
            else if (q.size() > 0 && !out_ready && mcnt != 4'd15) mcnt = mcnt + 4'd1;
            if (flush) begin
                q.delete();
            end else begin
                acc = in_valid && (q.size() < 2);
                drn = (q.size() > 0) && out_ready;
                if (drn) void'(q.pop_front());
                if (acc) begin
                    if (in_bubble) begin
                        e.wb = '0; e.mem = '0; e.ex = '0;
                    end
                    q.push_back(e);
                end
            end
            tick();
            got = {out_wb, out_mem, out_ex, out_npc, out_rd1, out_rd2, out_imm, out_rt, out_rd};
            total_cnt++;
            if (out_valid !== (q.size() > 0)) begin
                $display("FAIL rnd_valid cyc %0d got %b exp %b", i, out_valid, q.size() > 0);
                errs++;
            end else pass_cnt++;
            total_cnt++;
            if (q.size() > 0 && got !== q[0]) begin
                $display("FAIL rnd_payload cyc %0d got %h exp %h", i, got, q[0]);
                errs++;
            end else if (q.size() == 0 && {out_wb, out_mem, out_ex} !== 9'h0) begin
                $display("FAIL rnd_gate cyc %0d got %h exp 0", i, {out_wb, out_mem, out_ex});
                errs++;
            end else pass_cnt++;
            total_cnt++;
            if (stall_cycles !== mcnt) begin
                $display("FAIL rnd_stall cyc %0d got %0d exp %0d", i, stall_cycles, mcnt);
                errs++;
            end else pass_cnt++;
            if (errs > 10) break;
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        drive_idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_wb     = 2'b11;
        in_rd1    = 32'h12345678;
        in_npc    = 32'h400;
        tick();
        in_npc = 32'h404;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1 || stall_cycles === 4'd0) $display("FAIL arst_pre got v=%b cnt=%0d exp v=1 cnt>0", out_valid, stall_cycles); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_npc !== 32'h0 || out_rd1 !== 32'h0 || out_wb !== 2'b00) $display("FAIL arst_data got npc=%h rd1=%h wb=%b exp 0", out_npc, out_rd1, out_wb); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4'd0) $display("FAIL arst_stall got %0d exp 0", stall_cycles); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL arst_ready got %b exp 1", in_ready); else pass_cnt++;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_npc    = 32'h408;
        tick();
        total_cnt++; if (out_valid !== 1'b1 || out_npc !== 32'h408) $display("FAIL arst_after got v=%b npc=%h exp v=1 npc=408", out_valid, out_npc); else pass_cnt++;
        drive_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_counter();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised ID/EX pipeline stage with valid/ready flow control, a 2-entry skid buffer, flush, and bubble (NOP) insertion.
- Lets decode stall, or be stalled, without combinational ready paths crossing the stage.
- Sits between the decode stage (register read, sign-extend, control gen) and the execute stage.
- Carries WB/MEM/EX control bundles plus NPC, two read operands, immediate and two register specifiers; adds a saturating back-pressure cycle counter for performance tuning.

Parameters:
- WB_W, 2, width of write-back control bundle
- MEM_W, 3, width of memory control bundle
- EX_W, 4, width of execute control bundle
- DATA_W, 32, width of npc/read-data/immediate fields
- REG_W, 5, width of register specifier fields
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  kill all held entries (branch/exception redirect)
- in_valid  in  1  decode presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_bubble  in  1  capture the presented entry as NOP (control fields forced 0)
- in_wb / in_mem / in_ex  in  WB_W / MEM_W / EX_W  control bundles
- in_npc, in_rd1, in_rd2, in_imm  in  DATA_W each  next PC, read data 1/2, sign-extended immediate
- in_rt, in_rd  in  REG_W each  instr[20:16], instr[15:11]
- out_valid  out  1  entry valid toward execute
- out_ready  in  1  execute accepts this cycle
- out_wb / out_mem / out_ex  out  WB_W / MEM_W / EX_W  registered control bundles
- out_npc, out_rd1, out_rd2, out_imm  out  DATA_W each  registered data
- out_rt, out_rd  out  REG_W each  registered specifiers
- stat_clr  in  1  synchronous clear of stall counter
- stall_cycles  out  CNT_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: both entries invalid; all output payload 0; out_valid 0; stall_cycles 0. in_ready = 1 once rst_n is high.
- Storage:
  - Main entry M drives the outputs.
  - Skid entry S holds one overflow entry.
- Handshake signals:
  - in_ready = !S.valid; a function of flops only, no combinational path from out_ready.
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready, where out_valid = M.valid.
- Update rules, in priority order:
  1. flush=1: M.valid <= 0 and S.valid <= 0. An input accepted in the same cycle is dropped. Payload registers hold.
  2. S.valid & drain: M <= S; S.valid <= 0.
  3. !S.valid & (!M.valid | drain): M <= accept ? input : invalid.
  4. !S.valid & M.valid & !drain & accept: S <= input.
  5. Otherwise hold.
- Timing:
  - Latency in->out is 1 cycle.
  - Sustained throughput is 1 entry/cycle while out_ready=1.
  - After S fills, in_ready deasserts the next cycle.
- Ordering: strict FIFO; S never overtakes M.
- Bubble: when accept & in_bubble, the captured wb/mem/ex bundles = 0, data and specifier fields pass through, and the entry is still valid and counted.
- Output gating: out_wb/out_mem/out_ex read 0 whenever out_valid=0, so no stale control reaches EX. Data fields show the last M payload and are don't-care when invalid.
- Stall counter:
  - Increments when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - stat_clr has priority over increment and forces 0 that cycle.
  - Not affected by flush.
- Reset asserted mid-operation: everything returns to reset values immediately; in-flight entries are lost.

Decomposition:
- Package id_ex_pkg: default width constants, plus a packed payload typedef {wb, mem, ex, npc, rd1, rd2, imm, rt, rd} and its width constant.
- Sub-module pipe_skid_buf: generic two-entry valid/ready skid buffer on a flat payload of parameter width, with flush input.
- id_ex_skid_stage wraps pipe_skid_buf and adds: bubble masking on input, control gating on output, and the stall counter.

Test Plan:
- Reset then stream: out_ready=1, in_valid=1 for 4 cycles, npc=0x4,0x8,0xC,0x10 -> out_npc shows same sequence 1 cycle later; in_ready stays 1; stall_cycles=0.
- Back-pressure: out_ready=0 while sending 3 entries (npc 0x100,0x104,0x108) -> first 2 accepted, in_ready=0 from third cycle, stall_cycles increments each cycle. Release out_ready -> 0x100 then 0x104 emerge in order, 0x108 then accepted, nothing lost or duplicated.
- Bubble: in_bubble=1 with in_wb=2'b11, in_mem=3'b101, in_ex=4'hF, in_rd1=0xDEADBEEF -> out_valid=1, out_wb=0, out_mem=0, out_ex=0, out_rd1=0xDEADBEEF.
- Flush with M and S both full and in_valid=1 same cycle -> next cycle out_valid=0, control outputs 0, in_ready=1; the next input emerges normally.
- Counter: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles -> stall_cycles=15. stat_clr pulsed during stall -> reads 0 next cycle, then increments again.
- Async reset: pull rst_n low mid-stream between clock edges -> out_valid and all outputs 0 immediately without a clock edge; after release, in_ready=1.
